// File: rtl/arb_rr_if.sv
// Request/grant bundle between N bus masters and the arbiter.
// The master side drives requests and locks, the arbiter (slave side) drives the grant.
interface arb_rr_if #(
   parameter int N = 4
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  request;
   logic [N-1:0]  lock;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [IW-1:0] grant_idx;

   modport master (
      output request,
      output lock,
      input  grant,
      input  grant_valid,
      input  grant_idx
   );

   modport slave (
      input  request,
      input  lock,
      output grant,
      output grant_valid,
      output grant_idx
   );
endinterface

// File: rtl/arb_rr.sv
// N-requester arbiter with a registered one-hot grant.
// Selection is round-robin (MODE=1) or fixed priority with index 0 highest (MODE=0).
// The current owner can hold the grant with lock. While another requester waits,
// the hold is cut off after MAX_HOLD consecutive edges; MAX_HOLD=0 never cuts it off.
module arb_rr #(
   parameter int N        = 4,
   parameter int MODE     = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic    clk,
   input  logic    reset,
   arb_rr_if.slave bus
);
   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int IW1 = IW + 1;
   localparam int HC  = $clog2(MAX_HOLD + 1);
   localparam int HW  = (HC > 4) ? HC : 4;
   localparam int HW1 = HW + 1;

   localparam logic [IW:0]   N_W      = IW1'(N);
   localparam logic [IW-1:0] LAST     = IW'(N - 1);
   localparam logic [HW:0]   HOLD_W   = HW1'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

   logic [N-1:0]  r_grant;
   logic          r_valid;
   logic [IW-1:0] r_idx;
   logic [IW-1:0] r_ptr;
   logic [HW-1:0] r_hold;

   logic          w_owner_lock;
   logic          w_others;
   logic          w_hold_ok;
   logic          w_keep;
   logic          w_found;
   logic [N-1:0]  w_cand;
   logic [N-1:0]  w_rot;
   logic [N-1:0]  w_win_oh;
   logic [IW-1:0] w_shift;
   logic [IW-1:0] w_off;
   logic [IW-1:0] w_win;
   logic [IW-1:0] w_win_p1;
   logic [IW:0]   w_sum;

   // r_grant is zero when idle, so the owner terms vanish without a separate valid check.
   assign w_owner_lock = |(r_grant & bus.request & bus.lock);
   assign w_others     = |(bus.request & ~r_grant);
   assign w_hold_ok    = (MAX_HOLD == 0) || (({1'b0, r_hold} + HW1'(1)) < HOLD_W);
   assign w_keep       = w_owner_lock && (w_hold_ok || !w_others);

   // A locked owner that reaches this point has exhausted its hold: exclude it.
   assign w_cand  = w_owner_lock ? (bus.request & ~r_grant) : bus.request;

   // Rotate the candidates so the search start sits at bit 0, then pick the lowest bit.
   assign w_shift = (MODE == 1) ? r_ptr : '0;
   assign w_rot   = N'({w_cand, w_cand} >> w_shift);
   assign w_found = |w_rot;

   // Lowest set bit of the rotated candidate vector.
   always_comb begin
      w_off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IW'(k);
         end
      end
   end

   assign w_sum    = {1'b0, w_shift} + {1'b0, w_off};
   assign w_win    = (w_sum >= N_W) ? IW'(w_sum - N_W) : IW'(w_sum);
   assign w_win_p1 = (w_win == LAST) ? '0 : w_win + IW'(1);
   assign w_win_oh = N'(1) << w_win;

   // Grant, pointer and hold counter update; reset wins over any lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_hold  <= '0;
      end else if (w_keep) begin
         r_hold  <= (r_hold == HOLD_SAT) ? r_hold : r_hold + HW'(1);
      end else if (w_found) begin
         r_grant <= w_win_oh;
         r_valid <= 1'b1;
         r_idx   <= w_win;
         r_ptr   <= w_win_p1;
         r_hold  <= '0;
      end else begin
         r_grant <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_hold  <= '0;
      end
   end

   assign bus.grant       = r_grant;
   assign bus.grant_valid = r_valid;
   assign bus.grant_idx   = r_idx;

   // Grant encoding stays consistent and the pointer never leaves 0..N-1.
   a_onehot : assert property (@(posedge clk) $onehot0(r_grant));
   a_valid  : assert property (@(posedge clk) r_valid == (|r_grant));
   a_idx    : assert property (@(posedge clk) r_valid ? (r_grant == (N'(1) << r_idx)) : (r_idx == '0));
   a_ptr    : assert property (@(posedge clk) r_ptr <= LAST);
endmodule

// File: doc/arb_rr.md
Name: arb_rr

Overview:
- Parametrised N-requester arbiter. Generalises the two-requester fixed-priority arbiter: configurable requester count, round-robin or fixed-priority mode, and per-requester grant lock with a bounded hold time.
- Sits between N bus masters and one shared resource.
- Grant is registered and one-hot.
- Same single-clock domain as the existing interface-based testbench (clk from top).

Parameters:
- N, 4, number of requesters (2..16).
- MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).
- MAX_HOLD, 4, max consecutive cycles a locked grant is held while another requester waits; 0 = unlimited.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset (sampled on posedge clk).
- request  input  N  per-requester request, bit i = requester i.
- lock  input  N  per-requester lock; lock[i] is meaningful only while requester i holds the grant.
- grant  output  N  registered one-hot grant, 0 when idle.
- grant_valid  output  1  high when any grant bit is set.
- grant_idx  output  $clog2(N)  index of granted requester, 0 when grant_valid=0.

Behaviour:
- Reset (sync, active-high, sampled on posedge clk): grant=0, grant_valid=0, grant_idx=0, internal ptr=0, hold_cnt=0. Reset has priority over everything, including an active lock.
- Latency: request and lock are sampled at posedge t; the resulting grant is visible after that edge (1-cycle registered latency).
- Internal state:
  - ptr: $clog2(N) bits, round-robin start index.
  - hold_cnt: counter of extra cycles the current owner has held the grant. Saturates at MAX_HOLD; at least 4 bits wide.
- Per edge (not in reset), with owner = grant_idx when grant_valid=1:
  - KEEP: applies when grant_valid && request[owner] && lock[owner] && (MAX_HOLD==0 || hold_cnt+1 < MAX_HOLD || no other request bit set).
    - grant unchanged, ptr unchanged, hold_cnt increments (saturating).
  - FORCED: applies when the owner is locked and requesting but the hold limit has been reached and another request is pending.
    - Arbitrate with the owner's request bit masked out.
  - ARBITRATE (all other cases): choose the winner from request (masked if FORCED).
    - MODE=1: first set bit scanning ptr, ptr+1, … N-1, 0, … ptr-1.
    - MODE=0: lowest set index.
    - Then grant = one-hot(winner), grant_idx = winner, grant_valid = 1, hold_cnt = 0, ptr = (winner+1) mod N. ptr is updated in both modes.
  - No request (after masking): grant=0, grant_valid=0, grant_idx=0, hold_cnt=0, ptr unchanged.
- Without lock, arbitration happens every cycle, so in MODE=1 continuous requesters rotate one cycle each.
- lock from a non-owner is ignored.
- When the owner drops request, lock is ignored and re-arbitration happens the same edge.
- Lock rising while the owner already holds the grant extends the hold from that edge. hold_cnt has already been reset to 0 on the grant edge.
- Wrap-around: ptr wraps from N-1 to 0.
- N not a power of 2: ptr never holds a value ≥ N.
- Invariant, checked by assertion: grant is zero or one-hot; grant_valid == |grant; grant_idx matches grant.

Test Plan (N=4, MODE=1, MAX_HOLD=4 unless noted):
- Reset: assert reset 2 cycles with request=1111 -> grant=0000, grant_valid=0, grant_idx=0 after each reset edge.
- Single request: request=0001 from cycle 1 -> grant=0001, grant_idx=0 one edge later. Drop request -> grant=0000, grant_valid=0 next edge.
- Round-robin: request=1111, lock=0000 held after reset -> grants 0001, 0010, 0100, 1000, 0001 on consecutive edges.
- Lock bound: request=0011, lock=0001 -> grant=0001 for exactly 4 edges, then 0010 for 1 edge, then 0001 again for 4 edges. With request=0001 only, the grant is held indefinitely.
- Fixed mode (MODE=0): request=0110 -> grant=0010 every edge. Then request=0111 -> grant=0001 next edge.
- Reset mid-lock: during a locked hold of 0001, pulse reset 1 cycle -> grant=0000 that edge. With request=1110 afterwards -> grant=0010 (ptr restarted at 0).
